// File: rtl/demux_1_to_n_stream.sv
// Registered 1:N valid/ready stream demultiplexer with optional packet-locked select and drop counter.
// Latency: 1 cycle from an accepted input beat to out_valid on the selected channel.
// Backpressure: in_ready follows only the selected channel's slot; out-of-range beats are always accepted and dropped.
module demux_1_to_n_stream #(
  parameter int N        = 8,
  parameter int W        = 8,
  parameter int SEL_W    = 3,
  parameter int PKT_MODE = 0,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic               in_last,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*W-1:0]     out_data,
  output logic [N-1:0]       out_last,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  // N widened by one bit so the range check also works when N == 2^SEL_W
  localparam logic [SEL_W:0]   N_LIM   = (SEL_W+1)'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   sel_eff;
  logic               sel_ok;
  logic               slot_rdy;
  logic               accept;
  logic               drop;
  logic [N-1:0]       load;
  logic [N-1:0]       out_valid_q;
  logic [N*W-1:0]     out_data_q;
  logic [N-1:0]       out_last_q;
  logic [CNT_W-1:0]   drop_cnt_q;

  // Inside a packet the latched select overrides whatever in_sel carries
  always_comb begin
    sel_eff = in_sel;
    if (PKT_MODE != 0 && state_q != IDLE) begin
      sel_eff = sel_q;
    end
  end

  assign sel_ok = {1'b0, sel_eff} < N_LIM;

  // Selected slot can take a beat if empty or draining this cycle
  always_comb begin
    slot_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sel_eff == SEL_W'(i)) begin
        slot_rdy = ~out_valid_q[i] | out_ready[i];
      end
    end
  end

  assign in_ready = sel_ok ? slot_rdy : 1'b1;
  assign accept   = in_valid & in_ready;
  assign drop     = accept & ~sel_ok;

  // One-hot load strobe for the destination channel
  always_comb begin
    load = '0;
    for (int i = 0; i < N; i++) begin
      load[i] = accept & sel_ok & (sel_eff == SEL_W'(i));
    end
  end

  // Per-channel one-entry output registers; reload wins over drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          out_valid_q[i]         <= 1'b1;
          out_data_q[i*W +: W]   <= in_data;
          out_last_q[i]          <= in_last;
        end else if (out_ready[i]) begin
          out_valid_q[i]         <= 1'b0;
        end
      end
    end
  end

  // Saturating count of discarded beats
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop && drop_cnt_q != CNT_MAX) begin
      drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  // Packet FSM state and locked select registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Packet FSM next state: lock on a non-last first beat, release on the last beat
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (PKT_MODE != 0 && accept) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            sel_d   = in_sel;
            state_d = sel_ok ? BUSY : DROP;
          end
        end
        BUSY, DROP: begin
          if (in_last) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_demux_1_to_n_stream.sv
// Bench for demux_1_to_n_stream in packet mode with a non-power-of-2 channel count.
// Stimulus tasks push expected beats into per-channel queues; a monitor pops them as channels drain.
// Drop counter and busy flag are compared every cycle against a packet-level reference model.
module tb_demux_1_to_n_stream;

  localparam int N        = 5;
  localparam int W        = 8;
  localparam int SEL_W    = 3;
  localparam int PKT_MODE = 1;
  localparam int CNT_W    = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [W-1:0]       in_data = '0;
  logic               in_last = 1'b0;
  logic [SEL_W-1:0]   in_sel = '0;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready = '1;
  logic [N*W-1:0]     out_data;
  logic [N-1:0]       out_last;
  logic [CNT_W-1:0]   drop_cnt;
  logic               busy;

  demux_1_to_n_stream #(
    .N(N), .W(W), .SEL_W(SEL_W), .PKT_MODE(PKT_MODE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: expected {last,data} per channel, packet lock, drop count
  logic [W:0] exp_q [N][$];
  int         drop_m   = 0;
  bit         in_pkt   = 1'b0;
  int         lock_sel = 0;
  int         n_chk    = 0;
  int         n_fail   = 0;
  bit         mon_en   = 1'b0;
  logic [W:0] mon_e;

  bit         rdy_rand = 1'b0;
  logic [N-1:0] rdy_fix = '1;

  always @(negedge clk) out_ready = rdy_rand ? N'($urandom) : rdy_fix;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input int sel, input logic [W-1:0] d, input bit last);
    int tgt;
    bit exp_rdy;
    bit done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = SEL_W'(sel);
    in_data  = d;
    in_last  = last;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      tgt = in_pkt ? lock_sel : sel;
      if (tgt >= N) exp_rdy = 1'b1;
      else          exp_rdy = (exp_q[tgt].size() == 0) || out_ready[tgt];
      chk("in_ready", in_ready, exp_rdy);
      if (in_ready) begin
        @(posedge clk);
        if (tgt < N)               exp_q[tgt].push_back({last, d});
        else if (drop_m < CNT_MAX) drop_m++;
        if (in_pkt) begin
          if (last) in_pkt = 1'b0;
        end else if (!last) begin
          in_pkt   = 1'b1;
          lock_sel = sel;
        end
        done = 1'b1;
        #1 in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: sel %0d got no in_ready within 200 cycles", sel);
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    for (int i = 0; i < N; i++) exp_q[i].delete();
    drop_m   = 0;
    in_pkt   = 1'b0;
    lock_sel = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: occupancy, drained beats, drop counter and busy flag every cycle
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        for (int i = 0; i < N; i++) begin
          chk("out_valid", out_valid[i], exp_q[i].size() != 0);
          if (out_valid[i] && out_ready[i] && exp_q[i].size() != 0) begin
            mon_e = exp_q[i].pop_front();
            chk("out_data", out_data[i*W +: W], mon_e[W-1:0]);
            chk("out_last", out_last[i], mon_e[W]);
          end
        end
        chk("drop_cnt", drop_cnt, drop_m);
        chk("busy", busy, in_pkt);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    #3;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);

    // Per-beat routing, all channels ready
    for (int s = 0; s < N; s++) send(s, 8'(8'h10 + s), 1'b1);
    idle(2);

    // Back-pressure on channel 3, released while the second beat waits
    rdy_fix = 5'b10111;
    fork
      begin
        send(3, 8'hA1, 1'b1);
        send(3, 8'hA2, 1'b1);
      end
      begin
        repeat (4) @(negedge clk);
        rdy_fix = '1;
      end
    join
    idle(3);

    // Out-of-range beats, then saturation
    for (int k = 0; k < 3; k++) send(6, 8'(k), 1'b1);
    idle(1);
    #3 chk("drop_three", drop_cnt, 3);
    for (int k = 0; k < 6; k++) send(7, 8'(k), 1'b1);
    idle(1);
    #3 chk("drop_sat", drop_cnt, CNT_MAX);

    // Packet lock: first beat selects ch2, later in_sel ignored
    rdy_rand = 1'b1;
    send(2, 8'h21, 1'b0);
    send(5, 8'h22, 1'b0);
    send(5, 8'h23, 1'b0);
    send(5, 8'h24, 1'b1);
    send(4, 8'h40, 1'b1);
    // Packet with an out-of-range first select is dropped whole
    send(6, 8'h60, 1'b0);
    send(1, 8'h61, 1'b0);
    send(1, 8'h62, 1'b1);
    idle(4);

    // Reset in the middle of a packet
    send(1, 8'h71, 1'b0);
    send(3, 8'h72, 1'b0);
    do_reset();
    #3;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    send(4, 8'h73, 1'b1);
    idle(3);

    // Randomised traffic with random packets and back-pressure
    for (int k = 0; k < 300; k++) begin
      send($urandom_range(0, 7), 8'($urandom), $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) idle(1);
    end

    // Drain everything
    rdy_rand = 1'b0;
    rdy_fix  = '1;
    idle(4);
    #3 chk("final_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
